// File: rtl/coeff_bank_writer.sv
// coeff_bank_writer
// Captures a coefficient on each load_coeff pulse, holds modwait high for
// WRITE_CYCLES cycles, then commits the value into a 4-entry bank feeding
// the FIR datapath. set_done pulses when entry 3 commits.
//
// Handshake: a load is accepted only when modwait reads 0 in the cycle
// load_coeff is high (state IDLE). A load while modwait = 1 is dropped and
// sets the sticky overlap_err flag instead.
//
// Optional build macro COEFF_CLAMP_EN: values above 1.0 (1 << (DATA_W-1))
// are saturated to 1.0 as they are written into the bank.
module coeff_bank_writer #(
  parameter int DATA_W       = 16,
  parameter int NUM_COEFF    = 4,
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_coeff,
  input  logic [1:0]        coefficient_num,
  input  logic [DATA_W-1:0] coeff_value,
  input  logic              clear_err,
  output logic              modwait,
  output logic [DATA_W-1:0] coeff0,
  output logic [DATA_W-1:0] coeff1,
  output logic [DATA_W-1:0] coeff2,
  output logic [DATA_W-1:0] coeff3,
  output logic              set_done,
  output logic              overlap_err
);

  localparam logic [3:0] LP_CNT_INIT = 4'(WRITE_CYCLES - 1);
  localparam logic [DATA_W-1:0] LP_ONE = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cnt;
  logic [1:0]        r_num;
  logic [DATA_W-1:0] r_val;
  logic [DATA_W-1:0] r_bank0;
  logic [DATA_W-1:0] r_bank1;
  logic [DATA_W-1:0] r_bank2;
  logic [DATA_W-1:0] r_bank3;
  logic              r_set_done;
  logic              r_overlap_err;

  logic              w_accept;
  logic              w_commit;
  logic              w_overlap;
  logic [DATA_W-1:0] w_commit_val;

  assign w_accept  = (r_state == ST_IDLE) && load_coeff;
  assign w_commit  = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_overlap = (r_state == ST_BUSY) && load_coeff;

`ifdef COEFF_CLAMP_EN
  // Saturate anything above 1.0 on its way into the bank; staging keeps the raw value.
  assign w_commit_val = (r_val > LP_ONE) ? LP_ONE : r_val;
`else
  assign w_commit_val = r_val;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> BUSY on an accepted load, BUSY -> IDLE on commit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (load_coeff) w_next_state = ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: modwait is the registered BUSY state itself.
  always_comb begin
    modwait = (r_state == ST_BUSY);
  end

  // Staging capture and write-latency countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
      r_num <= 2'd0;
      r_val <= '0;
    end else if (w_accept) begin
      r_cnt <= LP_CNT_INIT;
      r_num <= coefficient_num;
      r_val <= coeff_value;
    end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Bank commit and the one-cycle set_done pulse for entry 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank0    <= '0;
      r_bank1    <= '0;
      r_bank2    <= '0;
      r_bank3    <= '0;
      r_set_done <= 1'b0;
    end else begin
      r_set_done <= w_commit && (r_num == 2'd3);
      if (w_commit) begin
        case (r_num)
          2'd0:    r_bank0 <= w_commit_val;
          2'd1:    r_bank1 <= w_commit_val;
          2'd2:    r_bank2 <= w_commit_val;
          default: r_bank3 <= w_commit_val;
        endcase
      end
    end
  end

  // Sticky overlap flag; a new overlap beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)            r_overlap_err <= 1'b0;
    else if (w_overlap) r_overlap_err <= 1'b1;
    else if (clear_err) r_overlap_err <= 1'b0;
  end

  assign coeff0      = r_bank0;
  assign coeff1      = r_bank1;
  assign coeff2      = r_bank2;
  assign coeff3      = r_bank3;
  assign set_done    = r_set_done;
  assign overlap_err = r_overlap_err;

endmodule

// File: tb/tb_coeff_bank_writer.sv
// Bench for coeff_bank_writer: directed loads with hand-computed results.
// Drivers push the expected bank snapshot {coeff3,coeff2,coeff1,coeff0,set_done}
// for each commit; the monitor pops and compares when modwait falls.
module tb_coeff_bank_writer;

  localparam int DATA_W = 16;
  localparam int WC     = 2;
  localparam int VW     = 4 * DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_coeff = 1'b0;
  logic [1:0]        coefficient_num = 2'd0;
  logic [DATA_W-1:0] coeff_value = '0;
  logic              clear_err = 1'b0;
  logic              modwait;
  logic [DATA_W-1:0] coeff0, coeff1, coeff2, coeff3;
  logic              set_done;
  logic              overlap_err;

  always #5 clk = ~clk;

  coeff_bank_writer #(.DATA_W(DATA_W), .NUM_COEFF(4), .WRITE_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .load_coeff(load_coeff),
    .coefficient_num(coefficient_num), .coeff_value(coeff_value),
    .clear_err(clear_err), .modwait(modwait),
    .coeff0(coeff0), .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3),
    .set_done(set_done), .overlap_err(overlap_err)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0]     exp_q[$];
  logic [DATA_W-1:0] exp_bank[4];
  int n_checks = 0;
  int n_fail   = 0;
  int sd_count = 0;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_commit(input logic [1:0] num, input logic [DATA_W-1:0] stored);
    exp_bank[num] = stored;
    exp_q.push_back({exp_bank[3], exp_bank[2], exp_bank[1], exp_bank[0], num == 2'd3});
  endtask

  // Monitor: a falling modwait marks a commit (or an aborted write after reset).
  logic mw_q = 1'b0;
  always @(negedge clk) begin
    if (set_done) sd_count++;
    if (mw_q && !modwait) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 1, 0);
      end else begin
        check("commit_snapshot", {coeff3, coeff2, coeff1, coeff0, set_done}, exp_q.pop_front());
      end
    end else if (set_done) begin
      check("set_done_outside_commit", set_done, 0);
    end
    mw_q = modwait;
  end

  // ---------------- driver tasks ----------------
  // Waits (bounded) for modwait to drop; returns at the negedge where it reads 0.
  task automatic wait_idle();
    int guard = 0;
    while (modwait && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (modwait) check("wait_idle_timeout", 1, 0);
  endtask

  // Issues one load; no_gap drives it in the cycle modwait first reads 0.
  // Also measures how many cycles modwait stays high.
  task automatic do_load(input logic [1:0] num, input logic [DATA_W-1:0] val,
                         input logic [DATA_W-1:0] stored, input bit no_gap);
    int hi;
    if (!no_gap) @(negedge clk);
    load_coeff = 1'b1;
    coefficient_num = num;
    coeff_value = val;
    push_commit(num, stored);
    @(negedge clk);
    load_coeff = 1'b0;
    coefficient_num = $urandom_range(0, 3);
    coeff_value = DATA_W'($urandom_range(0, 65535));
    hi = 0;
    while (modwait && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    check("modwait_high_cycles", hi, WC);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sd_before;
    logic [DATA_W-1:0] clamp_exp;
    for (int i = 0; i < 4; i++) exp_bank[i] = '0;

    // Reset, then idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_bank", {coeff3, coeff2, coeff1, coeff0}, '0);
    check("reset_modwait", modwait, 0);
    check("reset_set_done", set_done, 0);
    check("reset_overlap_err", overlap_err, 0);

    // Single load: entry 1 = 0x1234, modwait high exactly WC cycles.
    do_load(2'd1, 16'h1234, 16'h1234, 1'b0);
    check("single_coeff1", coeff1, 16'h1234);
    check("single_others", {coeff3, coeff2, coeff0}, '0);

    // Upstream-style sequence with a one-cycle gap between loads.
    sd_before = sd_count;
    do_load(2'd0, 16'h0100, 16'h0100, 1'b0);
    do_load(2'd1, 16'h0200, 16'h0200, 1'b0);
    do_load(2'd2, 16'h0300, 16'h0300, 1'b0);
    do_load(2'd3, 16'h0400, 16'h0400, 1'b0);
    repeat (3) @(negedge clk);
    check("seq_set_done_once", sd_count - sd_before, 1);
    check("seq_bank", {coeff3, coeff2, coeff1, coeff0}, 64'h0400_0300_0200_0100);

    // Load in the very cycle modwait falls, then overwrite the same entry.
    do_load(2'd2, 16'h0BEE, 16'h0BEE, 1'b0);
    do_load(2'd2, 16'h0CAB, 16'h0CAB, 1'b1);
    check("nogap_overwrite", coeff2, 16'h0CAB);

    // Overlap: second load while busy is dropped and flags an error.
    push_commit(2'd0, 16'h0000); // reset bank model for the overlap scenario below
    exp_q.pop_back();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_bank[i] = '0;
    @(negedge clk);
    load_coeff = 1'b1; coefficient_num = 2'd2; coeff_value = 16'hAAAA;
    push_commit(2'd2, 16'hAAAA);
    @(negedge clk);
    coefficient_num = 2'd0; coeff_value = 16'h5555;
    @(negedge clk);
    load_coeff = 1'b0;
    check("overlap_set", overlap_err, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("overlap_bank", {coeff2, coeff0}, {16'hAAAA, 16'h0000});
    check("overlap_sticky", overlap_err, 1);
    pulse_clear();
    check("overlap_cleared", overlap_err, 0);

    // Overlap and clear in the same cycle: set wins.
    @(negedge clk);
    load_coeff = 1'b1; coefficient_num = 2'd1; coeff_value = 16'h0042;
    push_commit(2'd1, 16'h0042);
    @(negedge clk);
    coefficient_num = 2'd2; coeff_value = 16'hFFFF; clear_err = 1'b1;
    @(negedge clk);
    load_coeff = 1'b0; clear_err = 1'b0;
    check("set_beats_clear", overlap_err, 1);
    wait_idle();
    check("set_beats_clear_bank", {coeff2, coeff1}, {16'hAAAA, 16'h0042});
    pulse_clear();
    check("overlap_cleared2", overlap_err, 0);

    // Reset in the middle of a write to entry 3: write aborted, no set_done.
    sd_before = sd_count;
    @(negedge clk);
    load_coeff = 1'b1; coefficient_num = 2'd3; coeff_value = 16'h7777;
    @(negedge clk);
    load_coeff = 1'b0;
    check("midwrite_busy", modwait, 1);
    for (int i = 0; i < 4; i++) exp_bank[i] = '0;
    exp_q.push_back('0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midwrite_modwait", modwait, 0);
    repeat (4) @(negedge clk);
    check("midwrite_coeff3", coeff3, 16'h0000);
    check("midwrite_no_set_done", sd_count - sd_before, 0);

    // Values above 1.0: clamped only when COEFF_CLAMP_EN is built in.
`ifdef COEFF_CLAMP_EN
    clamp_exp = 16'h8000;
`else
    clamp_exp = 16'h9000;
`endif
    do_load(2'd0, 16'h9000, clamp_exp, 1'b0);
    check("clamp_above_one", coeff0, clamp_exp);
    do_load(2'd1, 16'h8000, 16'h8000, 1'b0);
    check("clamp_at_one", coeff1, 16'h8000);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
